icache_direct: RTL
==================

# icache_direct

Direct-mapped, read-only instruction cache between the datapath's instruction fetch port and the memory controller. Caches one 32-bit word per frame in 16 frames, answers hits in the same cycle, and services each miss with a single word fill from RAM through a request/wait handshake. It also keeps a free-running hit counter and supports a whole-cache invalidate (`flush`) for self-modifying code and halt dumps.

## Interface
Parameters:
- `SETS`, 16: number of frames; index width is log2(SETS) = 4.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset. Synchronous and active-high.
- `imemREN` in 1: datapath instruction read request.
- `imemaddr` in 32: datapath instruction address. Bits [1:0] are ignored.
- `ihit` out 1: requested word is valid on `imemload` this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: fill request to the memory controller.
- `iaddr` out 32: fill address, word aligned.
- `iwait` in 1: memory busy. Low while `iREN` is high means `iload` is valid this cycle.
- `iload` in 32: fill data from memory.
- `flush` in 1: invalidate all frames.
- `hit_count` out 32: number of cycles with `ihit` = 1.

## Operation
- Address split: tag = `imemaddr[31:6]` (26 bits), index = `imemaddr[5:2]`, offset = `[1:0]` (ignored).
- Per-frame storage: valid bit, 26-bit tag, 32-bit data.
- States:
  - IDLE: default state.
  - FETCH: fill in progress.
- IDLE behaviour:
  - hit = `imemREN` & valid[index] & (tag[index] == tag). This is combinational.
  - `ihit` = hit and `imemload` = data[index]. When there is no hit, `ihit` = 0 and `imemload` = 0.
  - On `imemREN` & !hit: latch `miss_addr` = {`imemaddr[31:2]`, 2'b00} and go to FETCH.
- FETCH behaviour:
  - `iREN` = 1 and `iaddr` = `miss_addr`; `ihit` = 0.
  - While `iwait` = 1, stay in FETCH.
  - When `iwait` = 0, write `iload`, tag and valid=1 into frame `miss_addr[5:2]`, then go to IDLE.
  - The fill always completes with the latched address, even if `imemREN` drops or `imemaddr` changes mid-fill.
- Outside FETCH: `iREN` = 0 and `iaddr` = 0.
- Flush:
  - In IDLE: clears every valid bit at the next edge. A hit in the same cycle is still reported.
  - In FETCH: sets `flush_pending`. The fill completes normally, then every valid bit is cleared at the edge after the fill edge, including the frame just filled. `flush_pending` is then cleared.
  - `flush` asserted in IDLE while a miss is detected: the transition to FETCH still occurs, and the valid bits are cleared at that same edge.
- `hit_count`:
  - Increments by 1 at each edge where `ihit` = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Not affected by `flush`.
- Reset (`RST` = 1 at an edge):
  - State returns to IDLE and all valid bits are cleared.
  - `flush_pending`, `miss_addr` and `hit_count` are cleared to 0.
  - Tag and data arrays need not be reset.
  - Reset during FETCH abandons the fill: `iREN` is 0 from the cycle after that edge.

## Timing
- Reset values of outputs: `ihit` 0, `imemload` 0, `iREN` 0, `iaddr` 0, `hit_count` 0.
- Hit latency: 0 cycles, because `ihit` is combinational from the request and array state.
- Miss latency:
  - Cycle 0: miss detected in IDLE.
  - Cycles 1 through N: FETCH, where N counts up to and including the first cycle with `iwait` = 0.
  - Cycle N+1: IDLE hit, `ihit` = 1.
  - Total with zero-wait memory: hit on the 3rd cycle of the request.
- `iREN` rises exactly one cycle after the miss and stays high until the cycle with `iwait` = 0 inclusive. It is never deasserted while `iwait` = 1.
- Only the fill writes the arrays, so at most one frame write happens per cycle.

## Test plan
- **Cold miss:**
  - Stimulus: reset, then `imemREN` = 1 with `imemaddr` = 0x00000040, and memory returns 0x8C220004 with `iwait` = 1 for 2 cycles.
  - Response: `iREN` high for 3 cycles with `iaddr` = 0x40, then `ihit` = 1 with `imemload` = 0x8C220004, and `hit_count` becomes 1.
- **Conflict eviction:**
  - Stimulus: fill 0x00000044, then read 0x00000084 (same index 1, different tag), then read 0x44 again.
  - Response: each access misses and refills; the final read refetches from RAM.
- **Address change mid-fill:**
  - Stimulus: miss on 0x100, then switch `imemaddr` to 0x200 during the `iwait` = 1 cycles.
  - Response: `iaddr` stays 0x100; after the fill, 0x100 is valid and 0x200 then misses.
- **Flush:**
  - In IDLE: fill 0x0 and 0x4, pulse `flush`. Both addresses miss afterwards.
  - During FETCH: pulse `flush` mid-fill. The fill completes, and the frame is invalid on the following cycle, so a re-request misses.
- **Reset mid-fill and counter wrap:**
  - Reset mid-fill: assert `RST` during FETCH. `iREN` = 0 on the next cycle and a reread of the same address misses.
  - Counter wrap: force `hit_count` to 0xFFFFFFFF and produce one hit. `hit_count` reads 0.

Source files
------------

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with single-word miss fill
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush,
    output logic [31:0] hit_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic              flush_pending_q, flush_pending_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic              iren_q, iren_d;
    logic [31:0]       iaddr_q, iaddr_d;

    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic              hit;
    logic              fill_we;
    logic              unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign fill_idx      = miss_addr_q[IDX_W+1:2];
    assign unused_offset = ^imemaddr[1:0];

    // Hit lookup is purely combinational so a hit costs no extra cycle; FETCH never reports a hit
    always_comb begin
        hit     = (state_q == IDLE) && imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        fill_we = (state_q == FETCH) && !iwait;
    end

    assign ihit      = hit;
    assign imemload  = hit ? data_q[req_idx] : 32'h0;
    assign iREN      = iren_q;
    assign iaddr     = iaddr_q;
    assign hit_count = hit_count_q;

    // Next-state logic: miss capture, fill completion, and deferred flush after an in-flight fill
    always_comb begin
        state_d         = state_q;
        miss_addr_d     = miss_addr_q;
        flush_pending_d = flush_pending_q;
        valid_d         = valid_q;
        hit_count_d     = hit_count_q + 32'(hit);
        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    state_d     = FETCH;
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                end
                if (flush || flush_pending_q) begin
                    valid_d         = '0;
                    flush_pending_d = 1'b0;
                end
            end
            FETCH: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (!iwait) begin
                    state_d           = IDLE;
                    valid_d[fill_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        iren_d  = (state_d == FETCH);
        iaddr_d = (state_d == FETCH) ? miss_addr_d : 32'h0;
    end

    // Control state and registered memory-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            miss_addr_q     <= 32'h0;
            flush_pending_q <= 1'b0;
            hit_count_q     <= 32'h0;
            valid_q         <= '0;
            iren_q          <= 1'b0;
            iaddr_q         <= 32'h0;
        end else begin
            state_q         <= state_d;
            miss_addr_q     <= miss_addr_d;
            flush_pending_q <= flush_pending_d;
            hit_count_q     <= hit_count_d;
            valid_q         <= valid_d;
            iren_q          <= iren_d;
            iaddr_q         <= iaddr_d;
        end
    end

    // Tag and data arrays; only a completing fill writes them, one frame per cycle
    always_ff @(posedge CLK) begin
        if (fill_we && !RST) begin
            tag_q[fill_idx]  <= miss_addr_q[31:IDX_W+2];
            data_q[fill_idx] <= iload;
        end
    end

endmodule
